alu_arb_ctrl: RTL
=================

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 The block SHALL have parameter FUNCTION_BITS, default 4, meaning the ALU select width.
REQ-002 The block SHALL have parameter DATA_LENGTH, default 16, meaning the operand/result width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 I_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 I_req0 / I_req1  in  1  requester 0/1 operation request, level, held until granted.
REQ-006 I_sel0 / I_sel1  in  FUNCTION_BITS  requested ALU function.
REQ-007 I_a0, I_b0 / I_a1, I_b1  in  DATA_LENGTH  requested operands.
REQ-008 I_cmp0 / I_cmp1  in  1  compare qualifier for subtract.
REQ-009 O_gnt0 / O_gnt1  out  1  one-cycle accept pulse; operands captured that cycle.
REQ-010 O_valid  out  1  response valid; O_id  out  1  requester owning the response.
REQ-011 O_result  out  DATA_LENGTH; O_carry  out  1; O_psr  out  16  captured ALU outputs.
REQ-012 I_rsp_ready  in  1  response consumer ready.
REQ-013 O_busy  out  1  high in every state except IDLE.
REQ-014 O_alu_a, O_alu_b  out  DATA_LENGTH; O_alu_sel  out  FUNCTION_BITS; O_alu_cmp  out  1  drive the shared ALU.
REQ-015 I_alu_s  in  DATA_LENGTH; I_alu_c  in  1; I_alu_psr  in  16  ALU result, carry-out, registered status word.

Function
REQ-016 The FSM SHALL have four states: IDLE, EXEC, FLAG, RESP.
REQ-017 IDLE: any request -> grant one requester, pulse its O_gnt, latch its sel/a/b/cmp and id, go EXEC; no request -> stay.
REQ-018 Single request SHALL be granted regardless of priority pointer.
REQ-019 Both requesting: grant the requester NOT granted most recently (round-robin); the pointer updates on every grant.
REQ-020 EXEC (1 cycle): drive ALU from latched registers; capture I_alu_s into O_result and I_alu_c into O_carry at the closing edge; go FLAG.
REQ-021 FLAG (1 cycle): capture I_alu_psr into O_psr (the ALU updates its status on the EXEC closing edge); go RESP.
REQ-022 RESP: O_valid=1 with stable O_id/O_result/O_carry/O_psr; leave to IDLE on the first edge with I_rsp_ready=1; otherwise hold all outputs.
REQ-023 Accept-to-O_valid latency SHALL be exactly 3 cycles; minimum issue interval 4 cycles.
REQ-024 Outside EXEC, O_alu_sel SHALL be 4'b0000 and O_alu_cmp 0, so the ALU status word is never disturbed by idle cycles.
REQ-025 No request SHALL be granted outside IDLE; O_gnt0 and O_gnt1 SHALL never be high together.
REQ-026 A request dropped before grant SHALL be ignored without side effect.
REQ-027 Non-arithmetic functions (status not updated by the ALU) SHALL still traverse FLAG and return the current I_alu_psr unchanged.

Reset
REQ-028 On I_rst_n=0 (any state, including mid-operation): state IDLE, O_gnt*=0, O_valid=0, O_busy=0, O_id=0, O_result=0, O_carry=0, O_psr=0, priority pointer favours requester 0; an in-flight operation is dropped with no response.
REQ-029 Reset deassertion SHALL take effect on the next rising clk; first grant possible in that cycle.

Structure
REQ-030 The shared package SHALL hold the state encoding, FUNCTION_BITS/DATA_LENGTH defaults, and ALU function constants (ADD=4'b0100, SUB=4'b0101, NOP=4'b0000).
REQ-031 The two-way round-robin arbiter SHALL be a sub-module alu_rr_arb2 (req[1:0], advance -> gnt[1:0], internal pointer).
REQ-032 The ALU itself SHALL remain external; the block only drives its ports.

Verification
REQ-033 Req0 ADD a=0x7FFF b=0x0001 -> gnt0 pulse, O_valid 3 cycles later, O_result=0x8000, O_carry=0, O_psr[5]=1, O_id=0.
REQ-034 Req1 SUB cmp=1 a=0x0005 b=0x0005 -> O_result=0x0000, O_psr[6]=1, O_psr[2]=0, O_id=1.
REQ-035 Both requesting continuously after reset -> grants alternate 0,1,0,1; never both gnt high.
REQ-036 I_rsp_ready=0 for 5 cycles in RESP -> O_valid and data held stable, no new grant; ready=1 -> IDLE next cycle.
REQ-037 I_rst_n pulsed low during EXEC -> all outputs zero immediately, no O_valid for the dropped operation, next request served normally.
REQ-038 Req0 with NOP sel -> O_psr equals previous operation's status word.

Source files
------------

// File: rtl/alu_arb_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arb_ctrl_pkg                                                      |
// | Shared state encoding, width defaults and ALU function codes.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package alu_arb_ctrl_pkg;

  localparam int c_function_bits = 4;
  localparam int c_data_length   = 16;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_exec = 2'd1;
  localparam logic [1:0] c_st_flag = 2'd2;
  localparam logic [1:0] c_st_resp = 2'd3;

  localparam logic [3:0] c_alu_nop = 4'b0000;
  localparam logic [3:0] c_alu_add = 4'b0100;
  localparam logic [3:0] c_alu_sub = 4'b0101;

endpackage
`default_nettype wire

// File: rtl/alu_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_rr_arb2                                                           |
// | Two-way round-robin arbiter; favours the requester not last granted.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // r_last = index granted most recently; reset value 1 favours requester 0
  logic r_last;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (advance && (|req)) begin
      r_last <= gnt[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arb_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arb_ctrl                                                          |
// | Arbitrates two requesters onto one external ALU and returns results.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module alu_arb_ctrl
  import alu_arb_ctrl_pkg::*;
#(
  parameter int FUNCTION_BITS = c_function_bits,
  parameter int DATA_LENGTH   = c_data_length
) (
  input  logic                     clk,
  input  logic                     I_rst_n,
  input  logic                     I_req0,
  input  logic                     I_req1,
  input  logic [FUNCTION_BITS-1:0] I_sel0,
  input  logic [FUNCTION_BITS-1:0] I_sel1,
  input  logic [DATA_LENGTH-1:0]   I_a0,
  input  logic [DATA_LENGTH-1:0]   I_b0,
  input  logic [DATA_LENGTH-1:0]   I_a1,
  input  logic [DATA_LENGTH-1:0]   I_b1,
  input  logic                     I_cmp0,
  input  logic                     I_cmp1,
  output logic                     O_gnt0,
  output logic                     O_gnt1,
  output logic                     O_valid,
  output logic                     O_id,
  output logic [DATA_LENGTH-1:0]   O_result,
  output logic                     O_carry,
  output logic [15:0]              O_psr,
  input  logic                     I_rsp_ready,
  output logic                     O_busy,
  output logic [DATA_LENGTH-1:0]   O_alu_a,
  output logic [DATA_LENGTH-1:0]   O_alu_b,
  output logic [FUNCTION_BITS-1:0] O_alu_sel,
  output logic                     O_alu_cmp,
  input  logic [DATA_LENGTH-1:0]   I_alu_s,
  input  logic                     I_alu_c,
  input  logic [15:0]              I_alu_psr
);

  logic [1:0]               r_state;
  logic [1:0]               w_next_state;
  logic [1:0]               w_arb_gnt;
  logic [1:0]               w_gnt;
  logic                     w_idle;
  logic [FUNCTION_BITS-1:0] r_sel;
  logic [DATA_LENGTH-1:0]   r_a;
  logic [DATA_LENGTH-1:0]   r_b;
  logic                     r_cmp;
  logic                     r_id;
  logic [DATA_LENGTH-1:0]   r_result;
  logic                     r_carry;
  logic [15:0]              r_psr;

  assign w_idle = (r_state == c_st_idle);

  alu_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (I_rst_n),
    .req     ({I_req1, I_req0}),
    .advance (w_idle),
    .gnt     (w_arb_gnt)
  );

  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (I_req0 || I_req1) w_next_state = c_st_exec;
      c_st_exec: w_next_state = c_st_flag;
      c_st_flag: w_next_state = c_st_resp;
      c_st_resp: if (I_rsp_ready) w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // Grants are gated by reset so no accept pulse escapes while held in reset
  always_comb begin
    w_gnt     = (w_idle && I_rst_n) ? w_arb_gnt : 2'b00;
    O_gnt0    = w_gnt[0];
    O_gnt1    = w_gnt[1];
    O_busy    = !w_idle;
    O_valid   = (r_state == c_st_resp);
    O_alu_sel = (r_state == c_st_exec) ? r_sel : FUNCTION_BITS'(c_alu_nop);
    O_alu_cmp = (r_state == c_st_exec) ? r_cmp : 1'b0;
  end

  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_sel    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cmp    <= 1'b0;
      r_id     <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_psr    <= '0;
    end else begin
      if (w_gnt[0]) begin
        r_sel <= I_sel0;
        r_a   <= I_a0;
        r_b   <= I_b0;
        r_cmp <= I_cmp0;
        r_id  <= 1'b0;
      end else if (w_gnt[1]) begin
        r_sel <= I_sel1;
        r_a   <= I_a1;
        r_b   <= I_b1;
        r_cmp <= I_cmp1;
        r_id  <= 1'b1;
      end
      if (r_state == c_st_exec) begin
        r_result <= I_alu_s;
        r_carry  <= I_alu_c;
      end
      // Status word is registered inside the ALU, so it is valid one cycle later
      if (r_state == c_st_flag) begin
        r_psr <= I_alu_psr;
      end
    end
  end

  assign O_id     = r_id;
  assign O_result = r_result;
  assign O_carry  = r_carry;
  assign O_psr    = r_psr;
  assign O_alu_a  = r_a;
  assign O_alu_b  = r_b;

endmodule
`default_nettype wire
